// File: rtl/stream_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// stream_mux_n_to_1
//
// Purpose:
//   Selects one of NUM_IN valid/ready input streams and forwards it through a
//   single registered output stage. The latency is one cycle and the mux
//   sustains one word per cycle. Two selection modes are available:
//     mode = 0 : explicit select. The channel index comes from 'select'.
//     mode = 1 : round-robin arbitration. Scanning starts at rr_ptr and wraps.
//   The output register also carries the index of the source channel, so
//   downstream logic can route the word.
//
// Optional feature (compile-time macro STREAM_MUX_XFER_COUNT_EN):
//   When the macro is defined, the module adds the output xfer_count[15:0].
//   This counter counts input transfers, saturates at 16'hFFFF and is cleared
//   by Reset. When the macro is undefined, both the port and the counter are
//   absent.
//
// Parameters:
//   WIDTH  : data word width in bits (>= 1)
//   NUM_IN : number of input channels (2..16, need not be a power of 2)
//   SEL_W  : select/source index width, must equal ceil(log2(NUM_IN))
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous, active-high reset
//   in_data    in   NUM_IN*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready (combinational)
//   mode       in   0 = explicit select, 1 = round-robin
//   select     in   channel index used when mode = 0
//   out_data   out  registered data
//   out_src    out  registered source channel index
//   out_valid  out  registered valid
//   out_ready  in   downstream ready
//   xfer_count out  16-bit saturating count of input transfers (macro only)
//
// Handshake semantics (valid/ready, both directions):
//   A word moves across an interface on a rising clock edge where valid and
//   ready are both high. A source that raises valid must keep the word stable
//   until the transfer happens. The mux may look at valid before it drives
//   ready. Here in_ready depends on in_valid in round-robin mode, and it also
//   depends on out_ready. The output side is fully registered, so no
//   combinational path runs from in_* to out_*.
// -----------------------------------------------------------------------------
module stream_mux_n_to_1 #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        select,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef STREAM_MUX_XFER_COUNT_EN
   ,
   output logic [15:0]             xfer_count
`endif
);

   // Round-robin start position. It always holds a legal channel index
   // (0..NUM_IN-1).
   logic [SEL_W-1:0] rr_ptr;

   logic             space;       // output register can accept a word this cycle
   logic             sel_ok;      // explicit select addresses an existing channel
   logic             rr_found;    // round-robin scan found a valid channel
   logic [SEL_W-1:0] rr_grant;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;        // input handshake completes this cycle

   assign space = !out_valid || out_ready;

   // The select value may be wider than needed when NUM_IN is not a power of
   // two. Codes past the last channel produce no grant at all.
   assign sel_ok = (32'(select) < NUM_IN);

   // Round-robin scan: rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ..., rr_ptr-1.
   // The first valid channel in this order wins.
   always_comb begin
      int idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_grant = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!rr_found && in_valid[idx]) begin
            rr_found = 1'b1;
            rr_grant = SEL_W'(idx);
         end
      end
   end

   // In explicit mode the grant ignores in_valid. The selected channel sees
   // ready as soon as space exists, whether or not it is presenting data.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      if (mode) begin
         grant_valid = rr_found;
         grant       = rr_grant;
      end else begin
         grant_valid = sel_ok;
         grant       = select;
      end
   end

   // Ready is held low while Reset is asserted. Any input handshake in that
   // cycle would be discarded anyway.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = !Reset && space && grant_valid && (grant == SEL_W'(i));
      end
   end

   // A transfer needs valid and ready on the same channel. At most one ready
   // bit is high, so an OR-reduce is enough.
   assign xfer = |(in_valid & in_ready);

   // Data steering is a decoded AND-OR, so the slice index never goes outside
   // the bus, even for out-of-range grant codes.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register and round-robin pointer.
   // - Input transfer: load the word. This covers a simultaneous output
   //   transfer, which keeps full throughput.
   // - Output transfer only: drop out_valid. Data and source keep their values.
   // - Stall: everything holds, because xfer cannot fire without space.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
            // Only arbitration moves the pointer. Explicit-mode traffic
            // leaves the fairness position untouched.
            if (mode) begin
               rr_ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_XFER_COUNT_EN
   // Saturating counter of accepted input words.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         xfer_count <= '0;
      end else if (xfer && (xfer_count != 16'hFFFF)) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n_to_1
//
// Directed bench for stream_mux_n_to_1. It uses two instances:
//   u4 : WIDTH=32, NUM_IN=4, SEL_W=2  (explicit select, backpressure, RR)
//   u5 : WIDTH=8,  NUM_IN=5, SEL_W=3  (RR wrap, out-of-range select)
// Each vector is applied at a falling edge. in_ready is checked 1 ns later.
// Registered outputs are checked 1 ns after the next rising edge.
// The saturating transfer counter is exercised only when
// STREAM_MUX_XFER_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_mux_n_to_1;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   // ---------------- u4 signals ----------------
   logic [127:0] d4;
   logic [3:0]   v4, r4;
   logic         m4;
   logic [1:0]   s4;
   logic [31:0]  od4;
   logic [1:0]   os4;
   logic         ov4, or4;
`ifdef STREAM_MUX_XFER_COUNT_EN
   logic [15:0]  xc4;
`endif

   // ---------------- u5 signals ----------------
   logic [39:0]  d5;
   logic [4:0]   v5, r5;
   logic         m5;
   logic [2:0]   s5;
   logic [7:0]   od5;
   logic [2:0]   os5;
   logic         ov5, or5;
`ifdef STREAM_MUX_XFER_COUNT_EN
   logic [15:0]  xc5;
`endif

   stream_mux_n_to_1 #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
      .Clk(Clk), .Reset(Reset), .in_data(d4), .in_valid(v4), .in_ready(r4),
      .mode(m4), .select(s4), .out_data(od4), .out_src(os4),
      .out_valid(ov4), .out_ready(or4)
`ifdef STREAM_MUX_XFER_COUNT_EN
      , .xfer_count(xc4)
`endif
   );

   stream_mux_n_to_1 #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u5 (
      .Clk(Clk), .Reset(Reset), .in_data(d5), .in_valid(v5), .in_ready(r5),
      .mode(m5), .select(s5), .out_data(od5), .out_src(os5),
      .out_valid(ov5), .out_ready(or5)
`ifdef STREAM_MUX_XFER_COUNT_EN
      , .xfer_count(xc5)
`endif
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Channel i of u4 carries tag + i. The expected out_data is written by
   // hand in the table.
   task automatic set_d4(input logic [31:0] tag);
      for (int i = 0; i < 4; i++) d4[i*32 +: 32] = tag + 32'(i);
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic        mode;
      logic [2:0]  sel;
      logic [4:0]  valid;
      logic        ordy;
      logic [31:0] tag;
      logic [4:0]  exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_od;
      logic [2:0]  exp_os;
   } vec_t;

   vec_t t4[19];
   vec_t t5[9];

   // Watchdog: the run is bounded even if something stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //              mode sel  valid     ordy tag            rdy       ov   od             os
      t4[0]  = '{1'b0, 3'd2, 5'b00100, 1'b1, 32'hDEADBEED, 5'b00100, 1'b1, 32'hDEADBEEF, 3'd2};
      t4[1]  = '{1'b0, 3'd2, 5'b00000, 1'b1, 32'h00000000, 5'b00100, 1'b0, 32'hDEADBEEF, 3'd2};
      t4[2]  = '{1'b0, 3'd1, 5'b00010, 1'b0, 32'h10000000, 5'b00010, 1'b1, 32'h10000001, 3'd1};
      t4[3]  = '{1'b0, 3'd1, 5'b00010, 1'b0, 32'h20000000, 5'b00000, 1'b1, 32'h10000001, 3'd1};
      t4[4]  = '{1'b0, 3'd1, 5'b00010, 1'b0, 32'h20000000, 5'b00000, 1'b1, 32'h10000001, 3'd1};
      t4[5]  = '{1'b0, 3'd1, 5'b00010, 1'b0, 32'h20000000, 5'b00000, 1'b1, 32'h10000001, 3'd1};
      t4[6]  = '{1'b0, 3'd1, 5'b00010, 1'b1, 32'h20000000, 5'b00010, 1'b1, 32'h20000001, 3'd1};
      t4[7]  = '{1'b1, 3'd0, 5'b01111, 1'b1, 32'h30000000, 5'b00001, 1'b1, 32'h30000000, 3'd0};
      t4[8]  = '{1'b1, 3'd0, 5'b01111, 1'b1, 32'h40000000, 5'b00010, 1'b1, 32'h40000001, 3'd1};
      t4[9]  = '{1'b1, 3'd0, 5'b01111, 1'b1, 32'h50000000, 5'b00100, 1'b1, 32'h50000002, 3'd2};
      t4[10] = '{1'b1, 3'd0, 5'b01111, 1'b1, 32'h60000000, 5'b01000, 1'b1, 32'h60000003, 3'd3};
      t4[11] = '{1'b1, 3'd0, 5'b01111, 1'b1, 32'h70000000, 5'b00001, 1'b1, 32'h70000000, 3'd0};
      t4[12] = '{1'b1, 3'd0, 5'b01101, 1'b1, 32'h80000000, 5'b00100, 1'b1, 32'h80000002, 3'd2};
      t4[13] = '{1'b1, 3'd0, 5'b01101, 1'b1, 32'h90000000, 5'b01000, 1'b1, 32'h90000003, 3'd3};
      t4[14] = '{1'b1, 3'd0, 5'b01101, 1'b1, 32'hA0000000, 5'b00001, 1'b1, 32'hA0000000, 3'd0};
      t4[15] = '{1'b1, 3'd0, 5'b01101, 1'b1, 32'hB0000000, 5'b00100, 1'b1, 32'hB0000002, 3'd2};
      t4[16] = '{1'b1, 3'd0, 5'b00000, 1'b1, 32'h00000000, 5'b00000, 1'b0, 32'hB0000002, 3'd2};
      t4[17] = '{1'b1, 3'd0, 5'b00011, 1'b0, 32'hC0000000, 5'b00001, 1'b1, 32'hC0000000, 3'd0};
      t4[18] = '{1'b0, 3'd3, 5'b01111, 1'b0, 32'hD0000000, 5'b00000, 1'b1, 32'hC0000000, 3'd0};

      // u5 data is fixed: channel i = 8'hA0 + i.
      t5[0]  = '{1'b1, 3'd0, 5'b01000, 1'b1, 32'h0, 5'b01000, 1'b1, 32'hA3, 3'd3};
      t5[1]  = '{1'b1, 3'd0, 5'b10001, 1'b1, 32'h0, 5'b10000, 1'b1, 32'hA4, 3'd4};
      t5[2]  = '{1'b1, 3'd0, 5'b10001, 1'b1, 32'h0, 5'b00001, 1'b1, 32'hA0, 3'd0};
      t5[3]  = '{1'b0, 3'd6, 5'b11111, 1'b1, 32'h0, 5'b00000, 1'b0, 32'hA0, 3'd0};
      t5[4]  = '{1'b0, 3'd6, 5'b11111, 1'b0, 32'h0, 5'b00000, 1'b0, 32'hA0, 3'd0};
      t5[5]  = '{1'b0, 3'd5, 5'b11111, 1'b1, 32'h0, 5'b00000, 1'b0, 32'hA0, 3'd0};
      t5[6]  = '{1'b0, 3'd7, 5'b11111, 1'b1, 32'h0, 5'b00000, 1'b0, 32'hA0, 3'd0};
      t5[7]  = '{1'b0, 3'd4, 5'b11111, 1'b1, 32'h0, 5'b10000, 1'b1, 32'hA4, 3'd4};
      t5[8]  = '{1'b1, 3'd0, 5'b10001, 1'b1, 32'h0, 5'b10000, 1'b1, 32'hA4, 3'd4};

      for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'hA0 + 8'(i);

      // ---------------- reset with all inputs valid ----------------
      Reset = 1'b1;
      m4 = 1'b1; s4 = 2'd0; v4 = 4'hF; or4 = 1'b1; set_d4(32'h11110000);
      m5 = 1'b1; s5 = 3'd0; v5 = 5'h1F; or5 = 1'b1;
      @(negedge Clk); #1;
      chk("rst_c1 u4 in_ready", 32'(r4), 32'h0);
      chk("rst_c1 u5 in_ready", 32'(r5), 32'h0);
      @(posedge Clk); #1;
      chk("rst_c2 u4 in_ready", 32'(r4), 32'h0);
      chk("rst_c2 u5 in_ready", 32'(r5), 32'h0);
      chk("rst u4 out_valid", 32'(ov4), 32'h0);
      chk("rst u4 out_data",  od4,      32'h0);
      chk("rst u4 out_src",   32'(os4), 32'h0);
      chk("rst u5 out_valid", 32'(ov5), 32'h0);
      chk("rst u5 out_data",  32'(od5), 32'h0);
      chk("rst u5 out_src",   32'(os5), 32'h0);
`ifdef STREAM_MUX_XFER_COUNT_EN
      chk("rst u4 xfer_count", 32'(xc4), 32'h0);
`endif
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("post_rst u4 first rr grant", 32'(r4), 32'h1);
      chk("post_rst u5 first rr grant", 32'(r5), 32'h1);
      #1;
      v4 = 4'h0; v5 = 5'h0;   // withdraw before the edge: no transfer

      // ---------------- u4 table ----------------
      foreach (t4[n]) begin
         @(negedge Clk);
         m4 = t4[n].mode; s4 = t4[n].sel[1:0]; v4 = t4[n].valid[3:0];
         or4 = t4[n].ordy; set_d4(t4[n].tag);
         #1;
         chk($sformatf("u4 v%0d in_ready", n), 32'(r4), 32'(t4[n].exp_rdy));
         @(posedge Clk); #1;
         chk($sformatf("u4 v%0d out_valid", n), 32'(ov4), 32'(t4[n].exp_ov));
         chk($sformatf("u4 v%0d out_data", n),  od4,      t4[n].exp_od);
         chk($sformatf("u4 v%0d out_src", n),   32'(os4), 32'(t4[n].exp_os));
      end

      // ---------------- reset wins over a simultaneous transfer ----------------
      @(negedge Clk);
      Reset = 1'b1; m4 = 1'b1; v4 = 4'hF; or4 = 1'b1; set_d4(32'hE0000000);
      #1;
      chk("rst_win u4 in_ready", 32'(r4), 32'h0);
      @(posedge Clk); #1;
      chk("rst_win u4 out_valid", 32'(ov4), 32'h0);
      chk("rst_win u4 out_data",  od4,      32'h0);
      chk("rst_win u4 out_src",   32'(os4), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("rst_win u4 rr_ptr cleared", 32'(r4), 32'h1);
      #1;
      v4 = 4'h0;

      // ---------------- u5 table (wrap and out-of-range select) ----------------
      foreach (t5[n]) begin
         @(negedge Clk);
         m5 = t5[n].mode; s5 = t5[n].sel; v5 = t5[n].valid; or5 = t5[n].ordy;
         #1;
         chk($sformatf("u5 v%0d in_ready", n), 32'(r5), 32'(t5[n].exp_rdy));
         @(posedge Clk); #1;
         chk($sformatf("u5 v%0d out_valid", n), 32'(ov5), 32'(t5[n].exp_ov));
         chk($sformatf("u5 v%0d out_data", n),  32'(od5), t5[n].exp_od);
         chk($sformatf("u5 v%0d out_src", n),   32'(os5), 32'(t5[n].exp_os));
      end
      @(negedge Clk);
      v5 = 5'h0;

`ifdef STREAM_MUX_XFER_COUNT_EN
      // ---------------- saturating transfer counter ----------------
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("cnt u4 after reset", 32'(xc4), 32'h0);
      m4 = 1'b1; v4 = 4'hF; or4 = 1'b1;
      repeat (70000) @(posedge Clk);
      @(negedge Clk);
      chk("cnt u4 saturated", 32'(xc4), 32'hFFFF);
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      chk("cnt u4 holds", 32'(xc4), 32'hFFFF);
      Reset = 1'b1;
      @(posedge Clk); #1;
      chk("cnt u4 reset", 32'(xc4), 32'h0);
      @(negedge Clk);
      Reset = 1'b0; v4 = 4'h0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
